// File: rtl/lane_dly_seq.sv
// lane_dly_seq: DQS delay-line move/load sequencer for one DDR4 PHY lane.
// Define LANE_DLY_SEQ_PAUSE_EN to bracket each request with HS_IO_CLK_PAUSE.
module lane_dly_seq #(
    parameter int TAP_W         = 8,
    parameter int MAX_TAPS      = 255,
    parameter int SETTLE_CYCLES = 4,
    parameter int PAUSE_LEAD    = 2
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_SEL,
    input  logic             REQ_LOAD,
    input  logic             REQ_DIR,
    input  logic [TAP_W-1:0] REQ_STEPS,
    output logic             DONE,
    output logic [1:0]       DONE_STATUS,
    output logic             BUSY,
    output logic [TAP_W-1:0] RX_TAP,
    output logic [TAP_W-1:0] TX_TAP,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);
    // state   | meaning
    // IDLE    | ready, request captured on acceptance
    // PAUSE   | HS_IO_CLK_PAUSE lead-in
    // SETUP   | SEL/DIR presented, first limit check
    // MOVE    | single-tap move strobe
    // SETTLE  | wait after move, out-of-range sampled on last cycle
    // LOAD    | reload strobe
    // UNPAUSE | HS_IO_CLK_PAUSE lead-out
    // DONE    | completion pulse
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PAUSE   = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_MOVE    = 3'd3;
    localparam logic [2:0] ST_SETTLE  = 3'd4;
    localparam logic [2:0] ST_LOAD    = 3'd5;
    localparam logic [2:0] ST_UNPAUSE = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

`ifdef LANE_DLY_SEQ_PAUSE_EN
    localparam logic [2:0] ST_AFTER_IDLE = ST_PAUSE;
    localparam logic [2:0] ST_AFTER_WORK = ST_UNPAUSE;
`else
    localparam logic [2:0] ST_AFTER_IDLE = ST_SETUP;
    localparam logic [2:0] ST_AFTER_WORK = ST_DONE;
`endif

    localparam logic [1:0] STS_OK    = 2'b00;
    localparam logic [1:0] STS_OOR   = 2'b01;
    localparam logic [1:0] STS_LIMIT = 2'b10;

    localparam int CNT_MAX = (SETTLE_CYCLES > PAUSE_LEAD) ? SETTLE_CYCLES : PAUSE_LEAD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_LEAD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_ONE    = TAP_W'(1);
    localparam logic [TAP_W-1:0] MAX_T      = TAP_W'(MAX_TAPS);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] steps_q, steps_d;
    logic             sel_q, sel_d, dir_q, dir_d, load_q, load_d;
    logic [1:0]       status_q, status_d, done_status_q, done_status_d;
    logic [TAP_W-1:0] rx_tap_q, rx_tap_d, tx_tap_q, tx_tap_d;
    logic             dl_sel_q, dl_sel_d, dl_dir_q, dl_dir_d;
    logic [TAP_W-1:0] cur_tap, moved_tap;
    logic             at_limit, oor;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        steps_d       = steps_q;
        sel_d         = sel_q;
        dir_d         = dir_q;
        load_d        = load_q;
        status_d      = status_q;
        done_status_d = done_status_q;
        rx_tap_d      = rx_tap_q;
        tx_tap_d      = tx_tap_q;
        dl_sel_d      = dl_sel_q;
        dl_dir_d      = dl_dir_q;
        cur_tap       = sel_q ? tx_tap_q : rx_tap_q;
        at_limit      = dir_q ? (cur_tap == MAX_T) : (cur_tap == '0);
        oor           = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
        moved_tap     = cur_tap;
        if (!at_limit) begin
            moved_tap = dir_q ? (cur_tap + TAP_ONE) : (cur_tap - TAP_ONE);
        end

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    sel_d    = REQ_SEL;
                    dir_d    = REQ_DIR;
                    load_d   = REQ_LOAD;
                    steps_d  = REQ_STEPS;
                    status_d = STS_OK;
                    state_d  = ST_AFTER_IDLE;
                end
            end
            ST_PAUSE: begin
                if (cnt_q == '0) state_d = ST_SETUP;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            ST_SETUP: begin
                if (load_q) begin
                    state_d = ST_LOAD;
                end else if (steps_q == '0) begin
                    state_d = ST_AFTER_WORK;
                end else if (at_limit) begin
                    status_d = STS_LIMIT;
                    state_d  = ST_AFTER_WORK;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (sel_q) tx_tap_d = moved_tap;
                else       rx_tap_d = moved_tap;
                steps_d = steps_q - TAP_ONE;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (oor) begin
                    status_d = STS_OOR;
                    state_d  = ST_AFTER_WORK;
                end else if (steps_q == '0) begin
                    state_d = ST_AFTER_WORK;
                end else if (at_limit) begin
                    status_d = STS_LIMIT;
                    state_d  = ST_AFTER_WORK;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_LOAD: begin
                if (sel_q) tx_tap_d = '0;
                else       rx_tap_d = '0;
                state_d = ST_AFTER_WORK;
            end
            ST_UNPAUSE: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Timed states load their down-counter on entry and exit at zero.
        if (state_d != state_q) begin
            if (state_d == ST_PAUSE || state_d == ST_UNPAUSE) cnt_d = PAUSE_LOAD;
            else if (state_d == ST_SETTLE)                    cnt_d = SETTLE_LD;
        end
        if (state_d == ST_DONE) done_status_d = status_d;
        if (state_d inside {ST_SETUP, ST_MOVE, ST_SETTLE, ST_LOAD}) begin
            dl_sel_d = sel_d;
            dl_dir_d = dir_d;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            steps_q       <= '0;
            sel_q         <= 1'b0;
            dir_q         <= 1'b0;
            load_q        <= 1'b0;
            status_q      <= STS_OK;
            done_status_q <= STS_OK;
            rx_tap_q      <= '0;
            tx_tap_q      <= '0;
            dl_sel_q      <= 1'b0;
            dl_dir_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            steps_q       <= steps_d;
            sel_q         <= sel_d;
            dir_q         <= dir_d;
            load_q        <= load_d;
            status_q      <= status_d;
            done_status_q <= done_status_d;
            rx_tap_q      <= rx_tap_d;
            tx_tap_q      <= tx_tap_d;
            dl_sel_q      <= dl_sel_d;
            dl_dir_q      <= dl_dir_d;
        end
    end

    assign REQ_READY            = (state_q == ST_IDLE) && !RESET;
    assign DONE                 = (state_q == ST_DONE);
    assign DONE_STATUS          = done_status_q;
    assign BUSY                 = (state_q != ST_IDLE);
    assign RX_TAP               = rx_tap_q;
    assign TX_TAP               = tx_tap_q;
    assign DELAY_LINE_SEL       = dl_sel_q;
    assign DELAY_LINE_DIRECTION = dl_dir_q;
    assign DELAY_LINE_MOVE      = (state_q == ST_MOVE);
    assign DELAY_LINE_LOAD      = (state_q == ST_LOAD);
`ifdef LANE_DLY_SEQ_PAUSE_EN
    assign HS_IO_CLK_PAUSE      = (state_q != ST_IDLE) && (state_q != ST_DONE);
`else
    assign HS_IO_CLK_PAUSE      = 1'b0;
`endif

endmodule

// File: tb/tb_lane_dly_seq.sv
// Scoreboard bench for lane_dly_seq: requests push expected results, a monitor
// pops and compares on every DONE pulse.
module tb_lane_dly_seq;
    localparam int TAP_W    = 8;
    localparam int MAX_TAPS = 255;
    localparam int S        = 4;
    localparam int PL       = 2;
`ifdef LANE_DLY_SEQ_PAUSE_EN
    localparam int PL_EFF   = PL;
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam int PL_EFF   = 0;
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             RESET = 1'b1;
    logic             REQ_VALID = 1'b0, REQ_SEL = 1'b0, REQ_LOAD = 1'b0, REQ_DIR = 1'b0;
    logic [TAP_W-1:0] REQ_STEPS = '0;
    logic             REQ_READY, DONE, BUSY;
    logic [1:0]       DONE_STATUS;
    logic [TAP_W-1:0] RX_TAP, TX_TAP;
    logic             DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
    logic             HS_IO_CLK_PAUSE;
    logic             rx_oor = 1'b0, tx_oor = 1'b0;

    lane_dly_seq #(.TAP_W(TAP_W), .MAX_TAPS(MAX_TAPS), .SETTLE_CYCLES(S), .PAUSE_LEAD(PL)) dut (
        .FAB_CLK(clk), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL), .REQ_LOAD(REQ_LOAD),
        .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
        .DONE(DONE), .DONE_STATUS(DONE_STATUS), .BUSY(BUSY), .RX_TAP(RX_TAP), .TX_TAP(TX_TAP),
        .DELAY_LINE_SEL(DELAY_LINE_SEL), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
        .RX_DELAY_LINE_OUT_OF_RANGE(rx_oor), .TX_DELAY_LINE_OUT_OF_RANGE(tx_oor)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int k; int dcyc; bit sel; bit dir; bit load; int moves; int status; int rx; int tx;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int checks = 0, errors = 0;
    int m_rx = 0, m_tx = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: strobe protocol accumulated per request, full compare at DONE.
    int mv_cnt = 0, ld_cnt = 0, bad = 0, last_mv = 0, last_status = 0;
    always @(negedge clk) begin
        if (RESET) begin
            mv_cnt = 0; ld_cnt = 0; bad = 0; last_status = 0;
        end else if (q.size() > 0) begin
            mon_e = q[0];
            if (HS_IO_CLK_PAUSE !== (PAUSE_EN && cyc > mon_e.k && cyc < mon_e.dcyc)) bad++;
            if (BUSY !== (cyc > mon_e.k && cyc <= mon_e.dcyc)) bad++;
            if (DELAY_LINE_MOVE) begin
                if (mv_cnt > 0 && cyc - last_mv != 1 + S) bad++;
                if (DELAY_LINE_SEL !== mon_e.sel || DELAY_LINE_DIRECTION !== mon_e.dir) bad++;
                mv_cnt++;
                last_mv = cyc;
            end
            if (DELAY_LINE_LOAD) begin
                if (DELAY_LINE_SEL !== mon_e.sel) bad++;
                ld_cnt++;
            end
            if (!DONE && int'(DONE_STATUS) != last_status) bad++;
            if (DONE) begin
                chk("done_cycle", cyc, mon_e.dcyc);
                chk("done_status", int'(DONE_STATUS), mon_e.status);
                chk("rx_tap", int'(RX_TAP), mon_e.rx);
                chk("tx_tap", int'(TX_TAP), mon_e.tx);
                chk("move_pulses", mv_cnt, mon_e.moves);
                chk("load_pulses", ld_cnt, int'(mon_e.load));
                chk("strobe_protocol_errs", bad, 0);
                last_status = mon_e.status;
                void'(q.pop_front());
                mv_cnt = 0; ld_cnt = 0; bad = 0;
            end
        end else begin
            if ({DONE, DELAY_LINE_MOVE, DELAY_LINE_LOAD, HS_IO_CLK_PAUSE, BUSY} != 5'b0)
                chk("idle_quiet_strobes", int'({DONE, DELAY_LINE_MOVE, DELAY_LINE_LOAD,
                                                HS_IO_CLK_PAUSE, BUSY}), 0);
            if (int'(DONE_STATUS) != last_status)
                chk("done_status_hold", int'(DONE_STATUS), last_status);
        end
    end

    // Issue one request; the expectation comes from tap arithmetic, not state tracking.
    task automatic send(input bit sel, input bit load, input bit dir, input int steps,
                        input int oor_at, output int k, output int dcyc);
        int cur, head, planned, mv, st, ntap, m;
        exp_t e;
        for (int t = 0; t < 3000 && REQ_READY !== 1'b1; t++) tick();
        if (REQ_READY !== 1'b1) begin
            chk("ready_timeout", 0, 1);
            k = -1; dcyc = -1;
            return;
        end
        REQ_VALID = 1'b1; REQ_SEL = sel; REQ_LOAD = load; REQ_DIR = dir;
        REQ_STEPS = TAP_W'(steps);
        k = cyc;
        tick();
        REQ_VALID = 1'b0; REQ_SEL = 1'($urandom); REQ_LOAD = 1'($urandom);
        REQ_DIR = 1'($urandom); REQ_STEPS = TAP_W'($urandom);

        cur = sel ? m_tx : m_rx;
        if (load) begin
            mv = 0; st = 0; ntap = 0;
            dcyc = k + 2 * PL_EFF + 3;
        end else begin
            head    = dir ? MAX_TAPS - cur : cur;
            planned = (steps <= head) ? steps : head;
            if (oor_at >= 1 && oor_at <= planned) begin
                mv = oor_at; st = 1;
            end else begin
                mv = planned; st = (steps > head) ? 2 : 0;
            end
            ntap = dir ? cur + mv : cur - mv;
            dcyc = k + 2 * PL_EFF + mv * (1 + S) + 2;
        end
        if (sel) m_tx = ntap; else m_rx = ntap;
        e.k = k; e.dcyc = dcyc; e.sel = sel; e.dir = dir; e.load = load;
        e.moves = mv; e.status = st; e.rx = m_rx; e.tx = m_tx;
        q.push_back(e);

        if (st == 1) begin
            m = k + PL_EFF + 2 + (oor_at - 1) * (1 + S);
            while (cyc < m + 1) tick();
            if (sel) tx_oor = 1'b1; else rx_oor = 1'b1;
            while (cyc < m + S + 1) tick();
            tx_oor = 1'b0; rx_oor = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && q.size() > 0; t++) tick();
        if (q.size() > 0) begin
            chk("done_missing", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int k, d, k2, d2, target;
        repeat (3) tick();
        chk("ready_in_reset", int'(REQ_READY), 0);
        chk("outs_in_reset", int'({DONE, BUSY, HS_IO_CLK_PAUSE, DELAY_LINE_MOVE, DELAY_LINE_LOAD,
                                   DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DONE_STATUS}), 0);
        chk("taps_in_reset", int'({RX_TAP, TX_TAP}), 0);
        RESET = 1'b0;
        #1;
        chk("ready_after_reset", int'(REQ_READY), 1);

        send(0, 0, 1, 3, 0, k, d);          // RX +3 from 0
        drain();
        send(1, 0, 1, 1, 0, k, d);          // TX to 1
        send(1, 0, 0, 4, 0, k, d);          // TX -4 from 1: lower limit
        send(0, 1, 0, 0, 0, k, d);          // RX load
        send(0, 0, 1, 5, 2, k, d);          // RX +5, out-of-range in 2nd settle
        send(1, 0, 1, 7, 0, k, d);          // TX to 7
        send(1, 1, 0, 0, 0, k, d);          // TX load from 7
        send(0, 0, 0, 0, 0, k, d);          // zero steps
        send(0, 0, 1, 253, 0, k, d);        // RX 2 -> 255 exactly
        send(0, 0, 1, 3, 0, k, d);          // upper limit at setup
        send(0, 0, 0, 2, 0, k, d);
        drain();

        // Reset during the second settle of a 4-step request.
        send(1, 0, 1, 4, 0, k, d);
        target = k + PL_EFF + 2 + (1 + S) + 2;
        while (cyc < target) tick();
        RESET = 1'b1;
        q.delete();
        m_rx = 0; m_tx = 0;
        tick();
        chk("strobes_after_mid_reset", int'({DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_SEL,
                                             DELAY_LINE_DIRECTION, HS_IO_CLK_PAUSE, DONE, BUSY}), 0);
        chk("taps_after_mid_reset", int'({RX_TAP, TX_TAP}), 0);
        RESET = 1'b0;
        #1;
        chk("ready_after_mid_reset", int'(REQ_READY), 1);
        repeat (30) tick();

        send(0, 0, 1, 2, 0, k, d);
        send(1, 0, 1, 1, 0, k2, d2);
        chk("back_to_back_accept", k2, d + 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            bit rs, rl, rd;
            int st, oa;
            rs = 1'($urandom);
            rl = ($urandom_range(0, 7) == 0);
            rd = 1'($urandom);
            st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            oa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            send(rs, rl, rd, st, oa, k, d);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
